// File: rtl/dds_pkg.sv
// Shared definitions for the DDS keypad word-entry front end: field widths,
// cursor-to-field map, key FSM states and small combinational helpers.
package dds_pkg;

  localparam int F1_W  = 6;
  localparam int F2_W  = 8;
  localparam int P2_W  = 9;
  localparam int CUR_W = 3;

  localparam logic [CUR_W-1:0] CURSOR_MAX = 3'd6;

  // Cursor position -> edited field slice
  localparam logic [CUR_W-1:0] CUR_F1_HI  = 3'd0;  // Fword1[5:4]  <- key[1:0]
  localparam logic [CUR_W-1:0] CUR_F1_LO  = 3'd1;  // Fword1[3:0]
  localparam logic [CUR_W-1:0] CUR_F2_HI  = 3'd2;  // Fword2[7:4]
  localparam logic [CUR_W-1:0] CUR_F2_LO  = 3'd3;  // Fword2[3:0]
  localparam logic [CUR_W-1:0] CUR_P2_MSB = 3'd4;  // Pword2[8]    <- key[0]
  localparam logic [CUR_W-1:0] CUR_P2_HI  = 3'd5;  // Pword2[7:4]
  localparam logic [CUR_W-1:0] CUR_P2_LO  = 3'd6;  // Pword2[3:0]

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } key_state_e;

  typedef struct packed {
    logic [F1_W-1:0] f1;
    logic [F2_W-1:0] f2;
    logic [P2_W-1:0] p2;
  } words_t;

  // Number of asserted bits, saturated: 0, 1, or 2 meaning "two or more".
  function automatic logic [1:0] low_count(input logic [3:0] low);
    logic [2:0] sum;
    sum = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

  // Index of the lowest asserted bit (only meaningful when exactly one is set).
  function automatic logic [1:0] col_index(input logic [3:0] low);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Write a (truncated) key value into the digit selected by the cursor.
  function automatic words_t write_digit(input words_t w, input logic [CUR_W-1:0] cur,
                                         input logic [3:0] key);
    words_t r;
    r = w;
    case (cur)
      CUR_F1_HI:  r.f1[5:4] = key[1:0];
      CUR_F1_LO:  r.f1[3:0] = key;
      CUR_F2_HI:  r.f2[7:4] = key;
      CUR_F2_LO:  r.f2[3:0] = key;
      CUR_P2_MSB: r.p2[8]   = key[0];
      CUR_P2_HI:  r.p2[7:4] = key;
      CUR_P2_LO:  r.p2[3:0] = key;
      default:    r = w;
    endcase
    return r;
  endfunction

  // Cursor advance with wrap from the last digit back to 0.
  function automatic logic [CUR_W-1:0] cursor_next(input logic [CUR_W-1:0] cur);
    return (cur >= CURSOR_MAX) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/dds_word_entry_if.sv
// Keypad/button inputs and committed-word outputs of dds_word_entry.
// master: the environment (keypad, buttons, display); slave: the entry block.
interface dds_word_entry_if;
  import dds_pkg::*;

  logic [3:0]      col_input;
  logic            btn_next_n;
  logic            btn_load_n;
  logic [3:0]      row_output;
  logic [F1_W-1:0] Fword1;
  logic [F2_W-1:0] Fword2;
  logic [P2_W-1:0] Pword2;
  logic [CUR_W-1:0] cursor;
  logic            word_load;

  modport master (
    output col_input, btn_next_n, btn_load_n,
    input  row_output, Fword1, Fword2, Pword2, cursor, word_load
  );

  modport slave (
    input  col_input, btn_next_n, btn_load_n,
    output row_output, Fword1, Fword2, Pword2, cursor, word_load
  );

endinterface

// File: rtl/dds_word_entry_btn_debounce.sv
// Scan-tick-enabled push-button debouncer. A press is accepted after SCANS
// consecutive pressed ticks (one event pulse), and released after SCANS
// consecutive released ticks. No auto-repeat.
module btn_debounce
  import dds_pkg::*;
#(
  parameter int SCANS = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic press_i,
  output logic evt_o
);

  localparam logic [3:0] N = 4'(SCANS);

  key_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       evt_q, evt_d;

  // State, counter and event registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  // Accept/release decision, evaluated once per scan tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    evt_d   = 1'b0;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (press_i) begin
            state_d = DEBOUNCE;
            cnt_d   = 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end
        DEBOUNCE: begin
          if (press_i) begin
            if (cnt_q + 4'd1 == N) begin
              evt_d   = 1'b1;
              state_d = HOLD;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        HOLD: begin
          if (!press_i) begin
            if (cnt_q + 4'd1 == N) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/dds_word_entry.sv
// Keypad front end for the DDS: scans a 4x4 hex keypad, debounces keys and the
// next/load buttons at scan rate, edits a staged copy of Fword1/Fword2/Pword2
// one hex digit at a time and commits it to the outputs.
// Build option: WORD_ENTRY_AUTOLOAD_EN -- every digit write commits at once and
// the load button is ignored.
module dds_word_entry
  import dds_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            key_clock,
  input  logic            sys_rst_n,
  dds_word_entry_if.slave bus
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  // ---------------- row scan ----------------
  logic [3:0] row_q;
  logic [1:0] acc_cnt_q;
  logic [3:0] acc_code_q;

  logic [1:0] row_idx_s;
  logic       sample_valid_s;
  logic [3:0] low_s;
  logic [1:0] row_cnt_s;
  logic [1:0] base_cnt_s;
  logic [3:0] base_code_s;
  logic [2:0] sum_s;
  logic [1:0] tot_cnt_s;
  logic [3:0] tot_code_s;
  logic       scan_done_s;
  logic       scan_empty_s;

  // Decode the driven row and fold this row's columns into the scan result.
  always_comb begin
    row_idx_s      = 2'd0;
    sample_valid_s = 1'b1;
    case (row_q)
      4'b1110: row_idx_s = 2'd0;
      4'b1101: row_idx_s = 2'd1;
      4'b1011: row_idx_s = 2'd2;
      4'b0111: row_idx_s = 2'd3;
      default: sample_valid_s = 1'b0;
    endcase
    low_s       = ~bus.col_input;
    row_cnt_s   = low_count(low_s);
    base_cnt_s  = (row_idx_s == 2'd0) ? 2'd0 : acc_cnt_q;
    base_code_s = (row_idx_s == 2'd0) ? 4'd0 : acc_code_q;
    sum_s       = {1'b0, base_cnt_s} + {1'b0, row_cnt_s};
    tot_cnt_s   = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    if (row_cnt_s == 2'd1) begin
      tot_code_s = {row_idx_s, col_index(low_s)};
    end else begin
      tot_code_s = base_code_s;
    end
    scan_done_s  = sample_valid_s && (row_idx_s == 2'd3);
    scan_empty_s = (tot_cnt_s != 2'd1);
  end

  // Rotate the row drive and keep the running per-scan accumulation.
  always_ff @(posedge key_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      row_q      <= 4'b1111;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      if (sample_valid_s) begin
        row_q      <= {row_q[2:0], row_q[3]};
        acc_cnt_q  <= tot_cnt_s;
        acc_code_q <= tot_code_s;
      end else begin
        row_q <= 4'b1110;
      end
    end
  end

  assign bus.row_output = row_q;

  // ---------------- key FSM ----------------
  key_state_e key_state_q, key_state_d;
  logic [3:0] key_cnt_q, key_cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_evt_q, key_evt_d;

  // Key FSM registers.
  always_ff @(posedge key_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_state_q <= IDLE;
      key_cnt_q   <= 4'd0;
      key_code_q  <= 4'd0;
      key_evt_q   <= 1'b0;
    end else begin
      key_state_q <= key_state_d;
      key_cnt_q   <= key_cnt_d;
      key_code_q  <= key_code_d;
      key_evt_q   <= key_evt_d;
    end
  end

  // Key accept/release decision once per completed scan.
  always_comb begin
    key_state_d = key_state_q;
    key_cnt_d   = key_cnt_q;
    key_code_d  = key_code_q;
    key_evt_d   = 1'b0;
    if (scan_done_s) begin
      case (key_state_q)
        IDLE: begin
          if (!scan_empty_s) begin
            key_state_d = DEBOUNCE;
            key_cnt_d   = 4'd1;
            key_code_d  = tot_code_s;
          end else begin
            key_cnt_d = 4'd0;
          end
        end
        DEBOUNCE: begin
          if (!scan_empty_s && (tot_code_s == key_code_q)) begin
            if (key_cnt_q + 4'd1 == DEB_N) begin
              key_evt_d   = 1'b1;
              key_state_d = HOLD;
              key_cnt_d   = 4'd0;
            end else begin
              key_cnt_d = key_cnt_q + 4'd1;
            end
          end else begin
            key_state_d = IDLE;
            key_cnt_d   = 4'd0;
          end
        end
        HOLD: begin
          if (scan_empty_s) begin
            if (key_cnt_q + 4'd1 == DEB_N) begin
              key_state_d = IDLE;
              key_cnt_d   = 4'd0;
            end else begin
              key_cnt_d = key_cnt_q + 4'd1;
            end
          end else begin
            key_cnt_d = 4'd0;
          end
        end
        default: begin
          key_state_d = IDLE;
          key_cnt_d   = 4'd0;
        end
      endcase
    end else begin
      key_state_d = key_state_q;
    end
  end

  // ---------------- buttons ----------------
  logic next_evt_s;
  logic load_evt_s;

  btn_debounce #(.SCANS(DEBOUNCE_SCANS)) u_next_db (
    .clk_i  (key_clock),
    .rst_ni (sys_rst_n),
    .tick_i (scan_done_s),
    .press_i(~bus.btn_next_n),
    .evt_o  (next_evt_s)
  );

  btn_debounce #(.SCANS(DEBOUNCE_SCANS)) u_load_db (
    .clk_i  (key_clock),
    .rst_ni (sys_rst_n),
    .tick_i (scan_done_s),
    .press_i(~bus.btn_load_n),
    .evt_o  (load_evt_s)
  );

  // ---------------- digit editing and commit ----------------
  words_t           staged_q, staged_d;
  words_t           words_q, words_d;
  logic [CUR_W-1:0] cursor_q, cursor_d;
  logic             word_load_q, word_load_d;

  // Apply key/button events to staged words, cursor and committed words.
  always_comb begin
    staged_d    = staged_q;
    words_d     = words_q;
    cursor_d    = cursor_q;
    word_load_d = 1'b0;
    if (key_evt_q) begin
      staged_d = write_digit(staged_q, cursor_q, key_code_q);
    end else begin
      staged_d = staged_q;
    end
    if (key_evt_q || next_evt_s) begin
      cursor_d = cursor_next(cursor_q);
    end else begin
      cursor_d = cursor_q;
    end
`ifdef WORD_ENTRY_AUTOLOAD_EN
    if (key_evt_q) begin
      words_d     = staged_d;
      word_load_d = 1'b1;
    end else begin
      words_d = words_q;
    end
`else
    if (load_evt_s) begin
      words_d     = staged_d;
      word_load_d = 1'b1;
    end else begin
      words_d = words_q;
    end
`endif
  end

  // Edit state and committed output registers.
  always_ff @(posedge key_clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      staged_q    <= '0;
      words_q     <= '0;
      cursor_q    <= 3'd0;
      word_load_q <= 1'b0;
    end else begin
      staged_q    <= staged_d;
      words_q     <= words_d;
      cursor_q    <= cursor_d;
      word_load_q <= word_load_d;
    end
  end

  assign bus.Fword1    = words_q.f1;
  assign bus.Fword2    = words_q.f2;
  assign bus.Pword2    = words_q.p2;
  assign bus.cursor    = cursor_q;
  assign bus.word_load = word_load_q;

endmodule

// File: tb/tb_dds_word_entry.sv
// Directed self-checking bench for dds_word_entry with a behavioural 4x4 keypad.
module tb_dds_word_entry;
  import dds_pkg::*;

  logic        key_clock = 1'b0;
  logic        sys_rst_n;
  logic [15:0] pressed;
  int          vectors = 0;
  int          errs = 0;
  int          load_pulses = 0;
  logic [22:0] stg;

  always #5 key_clock = ~key_clock;

  dds_word_entry_if bus_if ();

  dds_word_entry #(.DEBOUNCE_SCANS(4)) dut (
    .key_clock(key_clock),
    .sys_rst_n(sys_rst_n),
    .bus      (bus_if.slave)
  );

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    bus_if.col_input = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!bus_if.row_output[r] && pressed[r*4+c]) bus_if.col_input[c] = 1'b0;
      end
    end
  end

  // Count word_load pulses, sampled mid-cycle.
  always @(negedge key_clock) begin
    if (bus_if.word_load === 1'b1) load_pulses++;
  end

  // Advance n complete scans; returns #1 after the row-3 sampling edge.
  task automatic run_scans(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(negedge key_clock);
      while (bus_if.row_output !== 4'b0111 && guard < 8) begin
        @(negedge key_clock);
        guard++;
      end
      if (guard >= 8) begin
        errs++;
        $display("FAIL scan_timeout: row_output=%b never reached 0111", bus_if.row_output);
      end
      @(posedge key_clock);
      #1;
    end
  endtask

  task automatic do_reset();
    pressed           = 16'h0;
    bus_if.btn_next_n = 1'b1;
    bus_if.btn_load_n = 1'b1;
    sys_rst_n         = 1'b0;
    repeat (2) @(posedge key_clock);
    @(negedge key_clock);
    sys_rst_n = 1'b1;
  endtask

  task automatic press_key(input int code);
    pressed = 16'h0;
    pressed[code] = 1'b1;
    run_scans(4);
    pressed = 16'h0;
    run_scans(4);
  endtask

  task automatic press_next();
    bus_if.btn_next_n = 1'b0;
    run_scans(4);
    bus_if.btn_next_n = 1'b1;
    run_scans(4);
  endtask

  task automatic test_reset();
    pressed           = 16'h0;
    bus_if.btn_next_n = 1'b1;
    bus_if.btn_load_n = 1'b1;
    sys_rst_n         = 1'b0;
    repeat (2) @(posedge key_clock);
    #1;
    stg = dut.staged_q;
    vectors++; if (bus_if.row_output !== 4'b1111) begin errs++; $display("FAIL reset_row: got %b want 1111", bus_if.row_output); end
    vectors++; if (bus_if.Fword1 !== 6'h00) begin errs++; $display("FAIL reset_f1: got %h want 00", bus_if.Fword1); end
    vectors++; if (bus_if.Fword2 !== 8'h00) begin errs++; $display("FAIL reset_f2: got %h want 00", bus_if.Fword2); end
    vectors++; if (bus_if.Pword2 !== 9'h000) begin errs++; $display("FAIL reset_p2: got %h want 000", bus_if.Pword2); end
    vectors++; if (bus_if.cursor !== 3'd0) begin errs++; $display("FAIL reset_cursor: got %0d want 0", bus_if.cursor); end
    vectors++; if (bus_if.word_load !== 1'b0) begin errs++; $display("FAIL reset_wload: got %b want 0", bus_if.word_load); end
    vectors++; if (stg !== 23'h0) begin errs++; $display("FAIL reset_staged: got %h want 0", stg); end
    @(negedge key_clock);
    sys_rst_n = 1'b1;
    @(posedge key_clock);
    #1;
    vectors++; if (bus_if.row_output !== 4'b1110) begin errs++; $display("FAIL first_row: got %b want 1110", bus_if.row_output); end
    @(posedge key_clock);
    #1;
    vectors++; if (bus_if.row_output !== 4'b1101) begin errs++; $display("FAIL second_row: got %b want 1101", bus_if.row_output); end
  endtask

  task automatic test_single_key();
    do_reset();
    pressed = 16'h0;
    pressed[5] = 1'b1;
    run_scans(4);
    vectors++; if (bus_if.cursor !== 3'd0) begin errs++; $display("FAIL single_at_E: cursor got %0d want 0", bus_if.cursor); end
    @(posedge key_clock);
    #1;
    stg = dut.staged_q;
    vectors++; if (bus_if.cursor !== 3'd1) begin errs++; $display("FAIL single_at_E1: cursor got %0d want 1", bus_if.cursor); end
    vectors++; if (stg !== {6'h10, 8'h00, 9'h000}) begin errs++; $display("FAIL single_staged: got %h want %h", stg, {6'h10, 8'h00, 9'h000}); end
`ifndef WORD_ENTRY_AUTOLOAD_EN
    vectors++; if (bus_if.Fword1 !== 6'h00) begin errs++; $display("FAIL single_commit: Fword1 got %h want 00", bus_if.Fword1); end
`endif
    run_scans(2);
    pressed = 16'h0;
    run_scans(4);
    vectors++; if (bus_if.cursor !== 3'd1) begin errs++; $display("FAIL single_once: cursor got %0d want 1", bus_if.cursor); end
  endtask

  task automatic test_enter_and_load();
    int p0;
    do_reset();
    press_key(3); press_key(10); press_key(7); press_key(12);
    press_key(1); press_key(15); press_key(0);
    stg = dut.staged_q;
    vectors++; if (stg !== {6'h3A, 8'h7C, 9'h1F0}) begin errs++; $display("FAIL enter_staged: got %h want %h", stg, {6'h3A, 8'h7C, 9'h1F0}); end
    vectors++; if (bus_if.cursor !== 3'd0) begin errs++; $display("FAIL enter_wrap: cursor got %0d want 0", bus_if.cursor); end
`ifndef WORD_ENTRY_AUTOLOAD_EN
    vectors++; if (bus_if.Fword2 !== 8'h00) begin errs++; $display("FAIL enter_nocommit: Fword2 got %h want 00", bus_if.Fword2); end
    p0 = load_pulses;
    bus_if.btn_load_n = 1'b0;
    run_scans(4);
    vectors++; if (bus_if.word_load !== 1'b0 || bus_if.Fword1 !== 6'h00) begin errs++; $display("FAIL load_at_E: wl=%b f1=%h want 0/00", bus_if.word_load, bus_if.Fword1); end
    @(posedge key_clock);
    #1;
    vectors++; if (bus_if.word_load !== 1'b1) begin errs++; $display("FAIL load_pulse: got %b want 1", bus_if.word_load); end
    vectors++; if (bus_if.Fword1 !== 6'h3A) begin errs++; $display("FAIL load_f1: got %h want 3A", bus_if.Fword1); end
    vectors++; if (bus_if.Fword2 !== 8'h7C) begin errs++; $display("FAIL load_f2: got %h want 7C", bus_if.Fword2); end
    vectors++; if (bus_if.Pword2 !== 9'h1F0) begin errs++; $display("FAIL load_p2: got %h want 1F0", bus_if.Pword2); end
    @(posedge key_clock);
    #1;
    vectors++; if (bus_if.word_load !== 1'b0) begin errs++; $display("FAIL load_width: got %b want 0", bus_if.word_load); end
    bus_if.btn_load_n = 1'b1;
    run_scans(4);
    vectors++; if (load_pulses - p0 !== 1) begin errs++; $display("FAIL load_count: got %0d want 1", load_pulses - p0); end
`endif
  endtask

  task automatic test_bounce_and_chord();
    pressed = 16'h0; pressed[6] = 1'b1;
    run_scans(2);
    pressed = 16'h0;
    run_scans(1);
    pressed[6] = 1'b1;
    run_scans(3);
    vectors++; if (bus_if.cursor !== 3'd0) begin errs++; $display("FAIL bounce_early: cursor got %0d want 0", bus_if.cursor); end
    run_scans(1);
    @(posedge key_clock);
    #1;
    stg = dut.staged_q;
    vectors++; if (bus_if.cursor !== 3'd1) begin errs++; $display("FAIL bounce_accept: cursor got %0d want 1", bus_if.cursor); end
    vectors++; if (stg[22:17] !== 6'h2A) begin errs++; $display("FAIL bounce_digit: f1 got %h want 2A", stg[22:17]); end
    pressed = 16'h0;
    run_scans(4);
    pressed[1] = 1'b1; pressed[2] = 1'b1;
    run_scans(6);
    pressed = 16'h0;
    run_scans(4);
    stg = dut.staged_q;
    vectors++; if (bus_if.cursor !== 3'd1) begin errs++; $display("FAIL chord_cursor: got %0d want 1", bus_if.cursor); end
    vectors++; if (stg[22:17] !== 6'h2A) begin errs++; $display("FAIL chord_digit: f1 got %h want 2A", stg[22:17]); end
  endtask

  task automatic test_next_wrap();
    do_reset();
    for (int i = 1; i <= 7; i++) begin
      press_next();
      vectors++; if (bus_if.cursor !== 3'(i % 7)) begin errs++; $display("FAIL next_step%0d: cursor got %0d want %0d", i, bus_if.cursor, i % 7); end
    end
  endtask

  task automatic test_back_to_back();
    press_next(); press_next(); press_next();
    pressed = 16'h0; pressed[11] = 1'b1;
    bus_if.btn_next_n = 1'b0;
    run_scans(4);
    @(posedge key_clock);
    #1;
    stg = dut.staged_q;
    vectors++; if (bus_if.cursor !== 3'd4) begin errs++; $display("FAIL coinc_cursor: got %0d want 4", bus_if.cursor); end
    vectors++; if (stg[16:9] !== 8'h0B) begin errs++; $display("FAIL coinc_digit: f2 got %h want 0B", stg[16:9]); end
    pressed = 16'h0;
    bus_if.btn_next_n = 1'b1;
    run_scans(4);
    vectors++; if (bus_if.cursor !== 3'd4) begin errs++; $display("FAIL coinc_single: cursor got %0d want 4", bus_if.cursor); end
  endtask

  task automatic test_reset_mid();
`ifndef WORD_ENTRY_AUTOLOAD_EN
    bus_if.btn_load_n = 1'b0;
    run_scans(4);
    bus_if.btn_load_n = 1'b1;
    run_scans(4);
`endif
    vectors++; if (bus_if.Fword2 !== 8'h0B) begin errs++; $display("FAIL premid_f2: got %h want 0B", bus_if.Fword2); end
    pressed = 16'h0; pressed[4] = 1'b1;
    run_scans(2);
    #3;
    sys_rst_n = 1'b0;
    #1;
    stg = dut.staged_q;
    vectors++; if (bus_if.row_output !== 4'b1111) begin errs++; $display("FAIL mid_row: got %b want 1111", bus_if.row_output); end
    vectors++; if ({bus_if.Fword1, bus_if.Fword2, bus_if.Pword2} !== 23'h0) begin errs++; $display("FAIL mid_words: got %h want 0", {bus_if.Fword1, bus_if.Fword2, bus_if.Pword2}); end
    vectors++; if (stg !== 23'h0) begin errs++; $display("FAIL mid_staged: got %h want 0", stg); end
    vectors++; if (bus_if.cursor !== 3'd0 || bus_if.word_load !== 1'b0) begin errs++; $display("FAIL mid_cursor: cursor=%0d wl=%b want 0/0", bus_if.cursor, bus_if.word_load); end
    vectors++; if (dut.key_state_q !== IDLE) begin errs++; $display("FAIL mid_fsm: got %0d want IDLE", dut.key_state_q); end
    pressed = 16'h0;
    @(negedge key_clock);
    sys_rst_n = 1'b1;
    @(posedge key_clock);
    #1;
    vectors++; if (bus_if.row_output !== 4'b1110) begin errs++; $display("FAIL mid_restart: got %b want 1110", bus_if.row_output); end
  endtask

`ifdef WORD_ENTRY_AUTOLOAD_EN
  task automatic test_autoload();
    int p0;
    do_reset();
    press_next();
    pressed = 16'h0; pressed[9] = 1'b1;
    run_scans(4);
    vectors++; if (bus_if.Fword1 !== 6'h00 || bus_if.word_load !== 1'b0) begin errs++; $display("FAIL auto_at_E: f1=%h wl=%b want 00/0", bus_if.Fword1, bus_if.word_load); end
    @(posedge key_clock);
    #1;
    vectors++; if (bus_if.Fword1 !== 6'h09) begin errs++; $display("FAIL auto_f1: got %h want 09", bus_if.Fword1); end
    vectors++; if (bus_if.word_load !== 1'b1) begin errs++; $display("FAIL auto_pulse: got %b want 1", bus_if.word_load); end
    pressed = 16'h0;
    run_scans(4);
    p0 = load_pulses;
    bus_if.btn_load_n = 1'b0;
    run_scans(4);
    bus_if.btn_load_n = 1'b1;
    run_scans(4);
    vectors++; if (load_pulses !== p0) begin errs++; $display("FAIL auto_noload: pulses got %0d want %0d", load_pulses, p0); end
  endtask
`endif

  initial begin
    pressed           = 16'h0;
    bus_if.btn_next_n = 1'b1;
    bus_if.btn_load_n = 1'b1;
    sys_rst_n         = 1'b0;
    test_reset();
    test_single_key();
    test_enter_and_load();
    test_bounce_and_chord();
    test_next_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef WORD_ENTRY_AUTOLOAD_EN
    test_autoload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
